// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_e;

endpackage

// File: rtl/four_bit_adder.sv
// 4-bit ripple-carry adder, time-shared by serial_addsub16 across nibbles.
module four_bit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_c4
);

    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_c4 = w_c[4];

endmodule

// File: rtl/serial_addsub16.sv
// Nibble-serial adder/subtractor: one 4-bit slice per clock through a shared
// four_bit_adder, with registered result, carry, overflow and zero flags.
module serial_addsub16
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NIBBLES-1:0]      result,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero,
    output addsub_state_e             o_dbg_state
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready/valid here are decoded from state alone.

    addsub_state_e r_state;
    addsub_state_e w_state_next;

    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_work;
    logic [W-1:0]        r_result;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic                r_zero;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum;
    logic                w_c4;
    logic [W-1:0]        w_work_next;
    logic                w_last;

    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_last  = (r_idx == LAST_IDX);

    four_bit_adder u_adder (
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_c4  (w_c4)
    );

    // Working value with the current sum nibble merged in, so the final
    // cycle can publish the completed result without an extra register stage.
    always_comb begin
        w_work_next = r_work;
        w_work_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {W{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_c4;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx    <= '0;
                        r_result <= w_work_next;
                        r_cout   <= w_c4;
                        r_ovf    <= (r_a[W-1] == r_b[W-1]) && (w_work_next[W-1] != r_a[W-1]);
                        r_zero   <= (w_work_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub16.sv
// Self-checking bench for serial_addsub16: directed cases, backpressure,
// mid-operation reset and randomized operations against a scoreboard queue.
module tb_serial_addsub16;
  import addsub_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
  localparam int EW = W + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] result;
  logic cout;
  logic ovf;
  logic zero;
  addsub_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  serial_addsub16 #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic c, input logic o, input logic z);
    return {r, c, o, z};
  endfunction

  // Reference: full-width arithmetic with two's-complement subtract.
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    logic [W:0] sum;
    logic [W-1:0] r;
    logic o;
    yy  = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    r   = sum[W-1:0];
    o   = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return pack(r, sum[W], o, (r == '0));
  endfunction

  task automatic check_out(input string tag, input logic [EW-1:0] e);
    check({tag, ".result"}, 32'(result), 32'(e[EW-1:3]));
    check({tag, ".cout"}, 32'(cout), 32'(e[2]));
    check({tag, ".ovf"}, 32'(ovf), 32'(e[1]));
    check({tag, ".zero"}, 32'(zero), 32'(e[0]));
  endtask

  // driver: called at a negedge with the DUT in IDLE; returns at the negedge after accept
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic [EW-1:0] e);
    a = x;
    b = y;
    sub = s;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(NIBBLES));
  endtask

  task automatic drain(input string tag, input int hold);
    logic [EW-1:0] e;
    check({tag, ".queue_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_out(tag, e);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [EW-1:0] e, input int hold);
    send(x, y, s, e);
    wait_result(tag);
    drain(tag, hold);
  endtask

  initial begin
    logic [EW-1:0] held;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic rs;
    int seen;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    check_out("rst", pack(16'h0000, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases with hand-derived expectations
    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, pack(16'h2233, 1'b0, 1'b0, 1'b0), 0);
    run_op("sub_zero", 16'h0005, 16'h0005, 1'b1, pack(16'h0000, 1'b1, 1'b0, 1'b1), 1);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, pack(16'h8000, 1'b0, 1'b1, 1'b0), 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, pack(16'h7FFF, 1'b1, 1'b1, 1'b0), 2);
    run_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, pack(16'hFFFE, 1'b0, 1'b0, 1'b0), 0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, pack(16'h0000, 1'b1, 1'b0, 1'b1), 0);

    // backpressure: DONE holds while in_valid pulses with other operands
    send(16'hA5A5, 16'h1111, 1'b0, pack(16'hB6B6, 1'b0, 1'b0, 1'b0));
    wait_result("bp");
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom_range(0, 1));
      check_out("bp.hold", held);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    a = 16'h0100;
    b = 16'h0011;
    sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.idle_in_ready", 32'(in_ready), 32'd1);
    check("bp.idle_out_valid", 32'(out_valid), 32'd0);
    check_out("bp.idle_hold", held);
    exp_q.push_back(pack(16'h0111, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp_next");
    drain("bp_next", 0);

    // reset two cycles after accept
    a = 16'h4321;
    b = 16'h1111;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstrun.in_ready", 32'(in_ready), 32'd1);
    check("rstrun.out_valid", 32'(out_valid), 32'd0);
    check("rstrun.state", 32'(dbg_state), 32'(IDLE));
    check_out("rstrun", pack(16'h0000, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstrun.no_out_valid", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, pack(16'h0002, 1'b0, 1'b0, 1'b0), 0);

    // randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i < 4) ry = rx;
      run_op("rand", rx, ry, rs, model(rx, ry, rs), $urandom_range(0, 3));
    end

    check("final.queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
